rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 Port: clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: head_deq, input, 1, ROB head entry is valid and complete.
REQ-005 Port: head_pc, input, 48, head entry PC.
REQ-006 Port: head_instr, input, 32, head entry instruction.
REQ-007 Port: head_lrd / head_prd / head_old_prd, input, LREG_RANGE / PREG_RANGE / PREG_RANGE, head entry destination registers.
REQ-008 Port: flush, input, 1, pipeline flush; blocks retirement this cycle.
REQ-009 Port: head_pop, output, 1, combinational ack; the ROB retires its head entry this cycle.
REQ-010 Port: commit_valid / commit_wen, output, 1 / 1, registered commit strobe and arch-RAT write enable.
REQ-011 Port: commit_lrd / commit_prd, output, LREG_RANGE / PREG_RANGE, arch-RAT update.
REQ-012 Port: commit_pc / commit_instr, output, 48 / 32, trace of the retired instruction.
REQ-013 Port: free_valid / free_preg / free_ready, output / output / input, 1 / PREG_RANGE / 1, freelist return handshake.
REQ-014 Port: instret, output, 64, count of retired instructions.

Function
REQ-015 head_pop SHALL equal head_deq & ~flush & ~reset & free_space, where free_space = (fifo_count < 2) | (free_valid & free_ready).
REQ-016 On head_pop, in the next cycle, commit_valid SHALL be 1 and commit_lrd/commit_prd SHALL hold the popped head_lrd/head_prd (one-cycle latency); otherwise commit_valid SHALL be 0.
REQ-017 commit_wen SHALL be 1 only when commit_valid is 1 and the popped lrd is nonzero.
REQ-018 A popped entry with lrd != 0 SHALL enqueue head_old_prd into a 2-entry free FIFO; lrd == 0 SHALL NOT enqueue.
REQ-019 free_valid SHALL be (fifo_count != 0), and free_preg SHALL be the oldest FIFO entry; an entry leaves on free_valid & free_ready.
REQ-020 A simultaneous enqueue and dequeue SHALL keep fifo_count unchanged and preserve order; with the FIFO full and no dequeue, head_pop SHALL be 0.
REQ-021 FIFO pointers SHALL be 1 bit each and wrap modulo 2; fifo_count SHALL be 2 bits and never exceed 2.
REQ-022 instret SHALL increment by 1 per head_pop and wrap from 2^64-1 to 0.
REQ-023 flush SHALL NOT drop FIFO contents, instret, or the commit registers already loaded; frees of retired instructions always drain.
REQ-024 free_valid SHALL stay asserted with free_preg stable until accepted.

Reset
REQ-025 While reset is high, head_pop SHALL be 0.
REQ-026 While reset is high, on each rising clock edge, commit_valid, commit_wen, commit_lrd, commit_prd, commit_pc, commit_instr, instret, fifo_count and the FIFO pointers SHALL clear to 0, so that free_valid reads 0.
REQ-027 A reset asserted mid-operation SHALL discard pending free entries and in-flight commit outputs.

Configuration
REQ-028 Macro ROB_COMMIT_TRACE_EN: when defined, commit_pc/commit_instr SHALL register the popped head_pc/head_instr with the same timing as commit_lrd.
REQ-029 When ROB_COMMIT_TRACE_EN is undefined, commit_pc/commit_instr SHALL be constant 0 with no trace registers; all other behaviour is unchanged.

Verification
REQ-030 V1: head_deq=1, lrd=5, prd=40, old_prd=12, free_ready=1 -> head_pop=1; next cycle commit_valid=1, commit_wen=1, commit_prd=40, free_valid=1, free_preg=12; instret=1.
REQ-031 V2: pop with lrd=0 -> commit_valid=1, commit_wen=0, free_valid stays 0.
REQ-032 V3: free_ready=0, three back-to-back heads with old_prd 7, 8, 9 -> 7 and 8 queued, head_pop=0 on the third; then free_ready=1 -> outputs 7 then 8, then 9 retires.
REQ-033 V4: flush=1 with head_deq=1 -> head_pop=0, instret unchanged, queued frees still drain.
REQ-034 V5: instret preloaded near 2^64-1 (force), then two pops -> instret=0 after wrap then 1.
REQ-035 V6: reset asserted with FIFO full and commit_valid=1 -> next cycle all outputs 0, free_valid=0.

Source files
------------

// File: rtl/rob_commit.sv
// ROB commit stage: retires the head entry, registers the arch-RAT update and returns old physical registers via a 2-entry free FIFO.
// Optional macro ROB_COMMIT_TRACE_EN adds registered commit_pc/commit_instr trace outputs.
module rob_commit #(
  parameter int unsigned LREG_W = 5,
  parameter int unsigned PREG_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              head_deq,
  input  logic [47:0]       head_pc,
  input  logic [31:0]       head_instr,
  input  logic [LREG_W-1:0] head_lrd,
  input  logic [PREG_W-1:0] head_prd,
  input  logic [PREG_W-1:0] head_old_prd,
  input  logic              flush,
  output logic              head_pop,
  output logic              commit_valid,
  output logic              commit_wen,
  output logic [LREG_W-1:0] commit_lrd,
  output logic [PREG_W-1:0] commit_prd,
  output logic [47:0]       commit_pc,
  output logic [31:0]       commit_instr,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  input  logic              free_ready,
  output logic [63:0]       instret
);

  logic [PREG_W-1:0] fifo_q [2];
  logic [PREG_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_count_q, fifo_count_d;

  logic              commit_valid_q, commit_valid_d;
  logic              commit_wen_q, commit_wen_d;
  logic [LREG_W-1:0] commit_lrd_q, commit_lrd_d;
  logic [PREG_W-1:0] commit_prd_q, commit_prd_d;
  logic [63:0]       instret_q, instret_d;

  logic fifo_enq;
  logic fifo_deq;
  logic free_space;

  // A full FIFO still accepts a new free when its oldest entry leaves this cycle.
  always_comb begin
    free_valid = (fifo_count_q != 2'd0);
    free_preg  = fifo_q[rd_ptr_q];
    fifo_deq   = free_valid & free_ready;
    free_space = (fifo_count_q < 2'd2) | fifo_deq;
    head_pop   = head_deq & ~flush & ~reset & free_space;
    fifo_enq   = head_pop & (head_lrd != '0);
  end

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;

    if (fifo_enq) begin
      fifo_d[wr_ptr_q] = head_old_prd;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (fifo_deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({fifo_enq, fifo_deq})
      2'b10:   fifo_count_d = fifo_count_q + 2'd1;
      2'b01:   fifo_count_d = fifo_count_q - 2'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_comb begin
    commit_valid_d = head_pop;
    commit_wen_d   = head_pop & (head_lrd != '0);
    commit_lrd_d   = commit_lrd_q;
    commit_prd_d   = commit_prd_q;
    instret_d      = instret_q;
    if (head_pop) begin
      commit_lrd_d = head_lrd;
      commit_prd_d = head_prd;
      instret_d    = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_count_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_wen_q   <= 1'b0;
      commit_lrd_q   <= '0;
      commit_prd_q   <= '0;
      instret_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_count_q   <= fifo_count_d;
      commit_valid_q <= commit_valid_d;
      commit_wen_q   <= commit_wen_d;
      commit_lrd_q   <= commit_lrd_d;
      commit_prd_q   <= commit_prd_d;
      instret_q      <= instret_d;
    end
  end

  // Storage needs no reset: fifo_count_q alone decides what is valid.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

  assign commit_valid = commit_valid_q;
  assign commit_wen   = commit_wen_q;
  assign commit_lrd   = commit_lrd_q;
  assign commit_prd   = commit_prd_q;
  assign instret      = instret_q;

`ifdef ROB_COMMIT_TRACE_EN
  logic [47:0] commit_pc_q, commit_pc_d;
  logic [31:0] commit_instr_q, commit_instr_d;

  always_comb begin
    commit_pc_d    = commit_pc_q;
    commit_instr_d = commit_instr_q;
    if (head_pop) begin
      commit_pc_d    = head_pc;
      commit_instr_d = head_instr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_pc_q    <= '0;
      commit_instr_q <= '0;
    end else begin
      commit_pc_q    <= commit_pc_d;
      commit_instr_q <= commit_instr_d;
    end
  end

  assign commit_pc    = commit_pc_q;
  assign commit_instr = commit_instr_q;
`else
  logic unused_trace;
  assign unused_trace = ^{head_pc, head_instr};
  assign commit_pc    = '0;
  assign commit_instr = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus random traffic against a queue-based reference model.
module tb_rob_commit;
  localparam int unsigned LW = 5;
  localparam int unsigned PW = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          head_deq;
  logic [47:0]   head_pc;
  logic [31:0]   head_instr;
  logic [LW-1:0] head_lrd;
  logic [PW-1:0] head_prd;
  logic [PW-1:0] head_old_prd;
  logic          flush;
  logic          head_pop;
  logic          commit_valid;
  logic          commit_wen;
  logic [LW-1:0] commit_lrd;
  logic [PW-1:0] commit_prd;
  logic [47:0]   commit_pc;
  logic [31:0]   commit_instr;
  logic          free_valid;
  logic [PW-1:0] free_preg;
  logic          free_ready;
  logic [63:0]   instret;

  rob_commit #(.LREG_W(LW), .PREG_W(PW)) dut (
    .clock(clock), .reset(reset), .head_deq(head_deq), .head_pc(head_pc),
    .head_instr(head_instr), .head_lrd(head_lrd), .head_prd(head_prd),
    .head_old_prd(head_old_prd), .flush(flush), .head_pop(head_pop),
    .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_lrd(commit_lrd),
    .commit_prd(commit_prd), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .free_valid(free_valid), .free_preg(free_preg), .free_ready(free_ready),
    .instret(instret)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model: frees are a plain queue, retirement is counted arithmetically.
  logic [PW-1:0] m_free[$];
  logic          m_cv;
  logic          m_wen;
  logic [LW-1:0] m_lrd;
  logic [PW-1:0] m_prd;
  logic [47:0]   m_pc;
  logic [31:0]   m_instr;
  logic [63:0]   m_instret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check, clock, advance model, return at next negedge.
  task automatic step(input logic rst, input logic deq, input logic fl, input logic rdy,
                      input logic [LW-1:0] lrd, input logic [PW-1:0] prd,
                      input logic [PW-1:0] old, input logic [47:0] pc, input logic [31:0] ins);
    logic m_pop;
    logic m_drain;
    reset = rst; head_deq = deq; flush = fl; free_ready = rdy;
    head_lrd = lrd; head_prd = prd; head_old_prd = old; head_pc = pc; head_instr = ins;
    #1;
    m_drain = (m_free.size() != 0) && rdy;
    m_pop   = deq && !fl && !rst && ((m_free.size() < 2) || m_drain);
    chk("head_pop", {63'd0, head_pop}, {63'd0, m_pop});
    chk("free_valid", {63'd0, free_valid}, {63'd0, m_free.size() != 0});
    if (m_free.size() != 0) chk("free_preg", {57'd0, free_preg}, {57'd0, m_free[0]});
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_cv});
    chk("commit_wen", {63'd0, commit_wen}, {63'd0, m_wen});
    if (m_cv) begin
      chk("commit_lrd", {59'd0, commit_lrd}, {59'd0, m_lrd});
      chk("commit_prd", {57'd0, commit_prd}, {57'd0, m_prd});
    end
    chk("commit_pc", {16'd0, commit_pc}, {16'd0, m_pc});
    chk("commit_instr", {32'd0, commit_instr}, {32'd0, m_instr});
    chk("instret", instret, m_instret);
    @(posedge clock);
    if (rst) begin
      m_free.delete();
      m_cv = 0; m_wen = 0; m_lrd = '0; m_prd = '0; m_pc = '0; m_instr = '0; m_instret = '0;
    end else begin
      if (m_drain) void'(m_free.pop_front());
      m_cv  = m_pop;
      m_wen = m_pop && (lrd != 0);
      if (m_pop) begin
        if (lrd != 0) m_free.push_back(old);
        m_lrd = lrd;
        m_prd = prd;
        m_instret = m_instret + 64'd1;
`ifdef ROB_COMMIT_TRACE_EN
        m_pc = pc;
        m_instr = ins;
`endif
      end
    end
    @(negedge clock);
  endtask

  initial begin
    m_cv = 0; m_wen = 0; m_lrd = '0; m_prd = '0; m_pc = '0; m_instr = '0; m_instret = '0;
    reset = 1; head_deq = 0; flush = 0; free_ready = 0;
    head_lrd = '0; head_prd = '0; head_old_prd = '0; head_pc = '0; head_instr = '0;
    @(negedge clock);
    step(1, 1, 0, 1, 5'd3, 7'd9, 7'd4, 48'h1, 32'h1);
    step(1, 0, 0, 0, 5'd0, 7'd0, 7'd0, 48'h0, 32'h0);

    // V1: ordinary retirement with a free.
    step(0, 1, 0, 1, 5'd5, 7'd40, 7'd12, 48'h1000, 32'h00500093);
    chk("v1_prd", {57'd0, commit_prd}, 64'd40);
    chk("v1_free_preg", {57'd0, free_preg}, 64'd12);
    chk("v1_instret", instret, 64'd1);
    step(0, 0, 0, 1, 5'd0, 7'd0, 7'd0, 48'h0, 32'h0);

    // V2: lrd == 0 commits without a free.
    step(0, 1, 0, 1, 5'd0, 7'd33, 7'd21, 48'h1004, 32'h00000013);
    chk("v2_wen", {63'd0, commit_wen}, 64'd0);
    step(0, 0, 0, 1, 5'd0, 7'd0, 7'd0, 48'h0, 32'h0);

    // V3: FIFO backpressure, then drain in order.
    step(0, 1, 0, 0, 5'd1, 7'd50, 7'd7, 48'h2000, 32'hA);
    step(0, 1, 0, 0, 5'd2, 7'd51, 7'd8, 48'h2004, 32'hB);
    step(0, 1, 0, 0, 5'd3, 7'd52, 7'd9, 48'h2008, 32'hC);
    step(0, 1, 0, 0, 5'd3, 7'd52, 7'd9, 48'h2008, 32'hC);
    step(0, 1, 0, 1, 5'd3, 7'd52, 7'd9, 48'h2008, 32'hC);
    chk("v3_second_free", {57'd0, free_preg}, 64'd8);

    // V4: flush blocks retirement but frees keep draining.
    step(0, 1, 1, 1, 5'd4, 7'd60, 7'd30, 48'h3000, 32'hD);
    step(0, 1, 1, 1, 5'd4, 7'd60, 7'd30, 48'h3000, 32'hD);
    step(0, 0, 0, 1, 5'd0, 7'd0, 7'd0, 48'h0, 32'h0);

    // V5: instret wraps.
    force dut.instret_q = '1;
    #1 release dut.instret_q;
    m_instret = '1;
    step(0, 1, 0, 1, 5'd0, 7'd1, 7'd0, 48'h4000, 32'hE);
    chk("v5_wrap", instret, 64'd0);
    step(0, 1, 0, 1, 5'd0, 7'd2, 7'd0, 48'h4004, 32'hF);
    chk("v5_after_wrap", instret, 64'd1);

    // V6: reset with a full FIFO and a live commit.
    step(0, 1, 0, 0, 5'd6, 7'd70, 7'd17, 48'h5000, 32'h10);
    step(0, 1, 0, 0, 5'd7, 7'd71, 7'd18, 48'h5004, 32'h11);
    step(1, 1, 0, 0, 5'd7, 7'd72, 7'd19, 48'h5008, 32'h12);
    chk("v6_free_valid", {63'd0, free_valid}, 64'd0);
    chk("v6_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("v6_instret", instret, 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [LW-1:0] rl;
      rl = ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, rl, PW'($urandom), PW'($urandom),
           {16'($urandom), $urandom}, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
